// File: rtl/fpu_out_pkg.sv
// Shared constants and types for the FPU output-stage arbiter.
package fpu_out_pkg;
  localparam int FPU_OUT_DIV = 2;
  localparam int FPU_OUT_MUL = 1;
  localparam int FPU_OUT_ADD = 0;

  typedef logic [2:0] fpu_sel_t;
endpackage

// File: rtl/fpu_out_credit.sv
// Up/down CPX credit counter: no decrement below zero, saturating increment
// at CREDITS, sticky error on a return that would overflow.
module fpu_out_credit #(
  parameter int CREDITS = 2,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          err_o
);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (dec_i && !inc_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end else if (inc_i && !dec_i) begin
      if (cnt_q == FULL) err_d = 1'b1;
      else               cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= FULL;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;
endmodule

// File: rtl/fpu_out_arb.sv
// FPU result-return arbiter: picks one of div/mul/add per cycle, stalls the
// losers, tracks CPX credits and promotes starved mul/add pipes.
module fpu_out_arb
  import fpu_out_pkg::*;
#(
  parameter int CREDITS    = 2,
  parameter int STARVE_LIM = 7
) (
  input  logic       rclk,
  input  logic       reset,
  input  logic       d8stg_div_vld,
  input  logic [1:0] d8stg_div_thr,
  input  logic       m6stg_mul_vld,
  input  logic [1:0] m6stg_mul_thr,
  input  logic       a6stg_add_vld,
  input  logic [1:0] a6stg_add_thr,
  input  logic       cpx_fp_credit_ret,
  output logic [2:0] dest_rdy,
  output logic [1:0] req_thread,
  output logic       div_hold,
  output logic       mul_hold,
  output logic       add_hold,
  output logic       fp_cpx_req_cq,
  output logic       credit_err
);
  localparam int          CW  = $clog2(CREDITS + 1);
  localparam logic [3:0]  LIM = 4'(STARVE_LIM);

  logic [CW-1:0] credit_cnt;
  logic [3:0]    mul_wait_q, mul_wait_d, add_wait_q, add_wait_d;
  logic          req_q;
  logic          can_grant;
  fpu_sel_t      sel;

  // Gated only by registered credit state, so a return can't reach dest_rdy
  // combinationally.
  assign can_grant = !reset && (credit_cnt != '0);

  always_comb begin
    sel = '0;
    if (can_grant) begin
      if (m6stg_mul_vld && mul_wait_q == LIM)      sel[FPU_OUT_MUL] = 1'b1;
      else if (a6stg_add_vld && add_wait_q == LIM) sel[FPU_OUT_ADD] = 1'b1;
      else if (d8stg_div_vld)                      sel[FPU_OUT_DIV] = 1'b1;
      else if (m6stg_mul_vld)                      sel[FPU_OUT_MUL] = 1'b1;
      else if (a6stg_add_vld)                      sel[FPU_OUT_ADD] = 1'b1;
    end
  end

  always_comb begin
    req_thread = 2'd0;
    if (sel[FPU_OUT_DIV])      req_thread = d8stg_div_thr;
    else if (sel[FPU_OUT_MUL]) req_thread = m6stg_mul_thr;
    else if (sel[FPU_OUT_ADD]) req_thread = a6stg_add_thr;
  end

  function automatic logic [3:0] next_wait(input logic vld, input logic won,
                                           input logic [3:0] q);
    if (!vld || won) return 4'd0;
    if (q == LIM)    return q;
    return q + 4'd1;
  endfunction

  assign mul_wait_d = next_wait(m6stg_mul_vld, sel[FPU_OUT_MUL], mul_wait_q);
  assign add_wait_d = next_wait(a6stg_add_vld, sel[FPU_OUT_ADD], add_wait_q);

  always_ff @(posedge rclk) begin
    if (reset) begin
      mul_wait_q <= 4'd0;
      add_wait_q <= 4'd0;
      req_q      <= 1'b0;
    end else begin
      mul_wait_q <= mul_wait_d;
      add_wait_q <= add_wait_d;
      req_q      <= |sel;
    end
  end

  fpu_out_credit #(.CREDITS(CREDITS), .CW(CW)) u_credit (
    .clk   (rclk),
    .rst   (reset),
    .dec_i (|sel),
    .inc_i (cpx_fp_credit_ret),
    .cnt_o (credit_cnt),
    .err_o (credit_err)
  );

  assign dest_rdy      = sel;
  assign div_hold      = d8stg_div_vld & ~sel[FPU_OUT_DIV];
  assign mul_hold      = m6stg_mul_vld & ~sel[FPU_OUT_MUL];
  assign add_hold      = a6stg_add_vld & ~sel[FPU_OUT_ADD];
  assign fp_cpx_req_cq = req_q;
endmodule

// File: tb/tb_fpu_out_arb.sv
// Directed bench for fpu_out_arb with CREDITS=2, STARVE_LIM=7.
module tb_fpu_out_arb;
  logic       rclk = 1'b0;
  logic       reset;
  logic       dv, mv, av, ret;
  logic [1:0] dt, mt, at;
  logic [2:0] dest_rdy;
  logic [1:0] req_thread;
  logic       div_hold, mul_hold, add_hold, fp_cpx_req_cq, credit_err;
  int         total = 0;
  int         bad = 0;

  always #5 rclk = ~rclk;

  fpu_out_arb #(.CREDITS(2), .STARVE_LIM(7)) dut (
    .rclk(rclk), .reset(reset),
    .d8stg_div_vld(dv), .d8stg_div_thr(dt),
    .m6stg_mul_vld(mv), .m6stg_mul_thr(mt),
    .a6stg_add_vld(av), .a6stg_add_thr(at),
    .cpx_fp_credit_ret(ret),
    .dest_rdy(dest_rdy), .req_thread(req_thread),
    .div_hold(div_hold), .mul_hold(mul_hold), .add_hold(add_hold),
    .fp_cpx_req_cq(fp_cpx_req_cq), .credit_err(credit_err)
  );

  task automatic tick();
    @(posedge rclk); #1;
  endtask

  task automatic drive(input logic d, input logic m, input logic a, input logic r);
    dv = d; mv = m; av = a; ret = r;
  endtask

  task automatic do_reset();
    reset = 1'b1; drive(0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; dt = 2'd1; mt = 2'd2; at = 2'd3;
    drive(1, 0, 1, 0);
    @(negedge rclk);
    total++; if (dest_rdy !== 3'b000) begin bad++; $display("FAIL rst_dest got=%b want=000", dest_rdy); end
    total++; if ({div_hold, mul_hold, add_hold} !== 3'b101) begin bad++; $display("FAIL rst_holds got=%b want=101", {div_hold, mul_hold, add_hold}); end
    tick(); tick();
    reset = 1'b0; drive(0, 0, 0, 0);
    total++; if (fp_cpx_req_cq !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", fp_cpx_req_cq); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", credit_err); end
    total++; if (dut.credit_cnt !== 2'd2) begin bad++; $display("FAIL rst_credits got=%0d want=2", dut.credit_cnt); end
    total++; if (dut.mul_wait_q !== 4'd0 || dut.add_wait_q !== 4'd0) begin bad++; $display("FAIL rst_waits got=%0d/%0d want=0/0", dut.mul_wait_q, dut.add_wait_q); end
  endtask

  task automatic test_priority();
    do_reset();
    drive(1, 1, 1, 1);
    @(negedge rclk);
    total++; if (dest_rdy !== 3'b100) begin bad++; $display("FAIL prio_dest got=%b want=100", dest_rdy); end
    total++; if (req_thread !== 2'd1) begin bad++; $display("FAIL prio_thr got=%0d want=1", req_thread); end
    total++; if ({div_hold, mul_hold, add_hold} !== 3'b011) begin bad++; $display("FAIL prio_holds got=%b want=011", {div_hold, mul_hold, add_hold}); end
    tick();
    drive(0, 0, 0, 0);
    total++; if (fp_cpx_req_cq !== 1'b1) begin bad++; $display("FAIL prio_req got=%b want=1", fp_cpx_req_cq); end
    @(negedge rclk);
    total++; if (dest_rdy !== 3'b000 || req_thread !== 2'd0) begin bad++; $display("FAIL idle_sel got=%b/%0d want=000/0", dest_rdy, req_thread); end
    tick();
    total++; if (fp_cpx_req_cq !== 1'b0) begin bad++; $display("FAIL idle_req got=%b want=0", fp_cpx_req_cq); end
  endtask

  task automatic test_credits();
    logic [2:0] exp_dest [5];
    logic [4:0] exp_ret;
    exp_dest = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b001};
    exp_ret  = 5'b01000;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 1, exp_ret[c]);
      @(negedge rclk);
      total++; if (dest_rdy !== exp_dest[c]) begin bad++; $display("FAIL cred_dest c%0d got=%b want=%b", c, dest_rdy, exp_dest[c]); end
      total++; if (add_hold !== ~exp_dest[c][0]) begin bad++; $display("FAIL cred_hold c%0d got=%b want=%b", c, add_hold, ~exp_dest[c][0]); end
      tick();
      total++; if (fp_cpx_req_cq !== exp_dest[c][0]) begin bad++; $display("FAIL cred_req c%0d got=%b want=%b", c, fp_cpx_req_cq, exp_dest[c][0]); end
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_starve();
    do_reset();
    dt = 2'd1; at = 2'd3;
    drive(1, 0, 1, 1);
    for (int c = 0; c < 7; c++) begin
      @(negedge rclk);
      total++; if (dest_rdy !== 3'b100 || add_hold !== 1'b1) begin bad++; $display("FAIL starve_wait c%0d got=%b/%b want=100/1", c, dest_rdy, add_hold); end
      tick();
    end
    total++; if (dut.add_wait_q !== 4'd7) begin bad++; $display("FAIL starve_cnt got=%0d want=7", dut.add_wait_q); end
    @(negedge rclk);
    total++; if (dest_rdy !== 3'b001 || req_thread !== 2'd3) begin bad++; $display("FAIL starve_grant got=%b/%0d want=001/3", dest_rdy, req_thread); end
    total++; if (div_hold !== 1'b1) begin bad++; $display("FAIL starve_divhold got=%b want=1", div_hold); end
    tick();
    total++; if (dut.add_wait_q !== 4'd0) begin bad++; $display("FAIL starve_clr got=%0d want=0", dut.add_wait_q); end
    @(negedge rclk);
    total++; if (dest_rdy !== 3'b100) begin bad++; $display("FAIL starve_back got=%b want=100", dest_rdy); end
    tick();
    drive(0, 0, 0, 0);
  endtask

  task automatic test_promote_both();
    do_reset();
    mt = 2'd2; at = 2'd3;
    drive(1, 1, 1, 1);
    for (int c = 0; c < 7; c++) tick();
    total++; if (dut.mul_wait_q !== 4'd7 || dut.add_wait_q !== 4'd7) begin bad++; $display("FAIL prom_cnt got=%0d/%0d want=7/7", dut.mul_wait_q, dut.add_wait_q); end
    @(negedge rclk);
    total++; if (dest_rdy !== 3'b010 || req_thread !== 2'd2) begin bad++; $display("FAIL prom_mul got=%b/%0d want=010/2", dest_rdy, req_thread); end
    tick();
    @(negedge rclk);
    total++; if (dest_rdy !== 3'b001 || req_thread !== 2'd3) begin bad++; $display("FAIL prom_add got=%b/%0d want=001/3", dest_rdy, req_thread); end
    tick();
    drive(0, 0, 0, 0);
  endtask

  task automatic test_back_to_back_credit();
    do_reset();
    drive(1, 0, 0, 0); tick();
    total++; if (dut.credit_cnt !== 2'd1) begin bad++; $display("FAIL bb_dec got=%0d want=1", dut.credit_cnt); end
    drive(1, 0, 0, 1);
    @(negedge rclk);
    total++; if (dest_rdy !== 3'b100) begin bad++; $display("FAIL bb_grant got=%b want=100", dest_rdy); end
    tick();
    total++; if (dut.credit_cnt !== 2'd1) begin bad++; $display("FAIL bb_same got=%0d want=1", dut.credit_cnt); end
    drive(0, 0, 0, 1); tick();
    total++; if (dut.credit_cnt !== 2'd2 || credit_err !== 1'b0) begin bad++; $display("FAIL bb_inc got=%0d/%b want=2/0", dut.credit_cnt, credit_err); end
    tick();
    total++; if (dut.credit_cnt !== 2'd2 || credit_err !== 1'b1) begin bad++; $display("FAIL bb_ovf got=%0d/%b want=2/1", dut.credit_cnt, credit_err); end
    drive(1, 0, 0, 0); tick(); tick();
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL bb_sticky got=%b want=1", credit_err); end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 1, 1, 0); tick(); tick();
    total++; if (dut.credit_cnt !== 2'd0 || fp_cpx_req_cq !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0d/%b want=0/1", dut.credit_cnt, fp_cpx_req_cq); end
    total++; if (dut.mul_wait_q !== 4'd2 || dut.add_wait_q !== 4'd2) begin bad++; $display("FAIL mid_waits got=%0d/%0d want=2/2", dut.mul_wait_q, dut.add_wait_q); end
    reset = 1'b1;
    @(negedge rclk);
    total++; if (dest_rdy !== 3'b000 || {div_hold, mul_hold, add_hold} !== 3'b111) begin bad++; $display("FAIL mid_rst got=%b/%b want=000/111", dest_rdy, {div_hold, mul_hold, add_hold}); end
    tick();
    reset = 1'b0; drive(0, 0, 0, 0);
    total++; if (dut.credit_cnt !== 2'd2 || fp_cpx_req_cq !== 1'b0 || credit_err !== 1'b0) begin bad++; $display("FAIL mid_post got=%0d/%b/%b want=2/0/0", dut.credit_cnt, fp_cpx_req_cq, credit_err); end
    total++; if (dut.mul_wait_q !== 4'd0 || dut.add_wait_q !== 4'd0) begin bad++; $display("FAIL mid_clr got=%0d/%0d want=0/0", dut.mul_wait_q, dut.add_wait_q); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_credits();
    test_starve();
    test_promote_both();
    test_back_to_back_credit();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpu_out_arb.md
# fpu_out_arb

Result-return arbiter and CPX credit controller for the FPU output stage. Each cycle it picks at most one of the divide, multiply and add pipes to drive its result into the output datapath. It drives the one-hot `dest_rdy[2:0]` select and `req_thread[1:0]` consumed by that datapath, and stalls the losing pipes. It also tracks free CPX queue slots, raises the CPX request in step with the registered result data, and keeps low-priority pipes from starving.

## Interface
Parameters:
- CREDITS, 2, number of CPX return-queue slots owned by the FPU (1..7)
- STARVE_LIM, 7, wait cycles after which a held pipe is promoted (1..15)

Ports:
- rclk  in  1  global clock; single clock domain
- reset  in  1  synchronous, active-high reset
- d8stg_div_vld  in  1  divide result valid this cycle
- d8stg_div_thr  in  2  divide result thread ID
- m6stg_mul_vld  in  1  multiply result valid this cycle
- m6stg_mul_thr  in  2  multiply result thread ID
- a6stg_add_vld  in  1  add result valid this cycle
- a6stg_add_thr  in  2  add result thread ID
- cpx_fp_credit_ret  in  1  one CPX slot freed this cycle
- dest_rdy  out  3  one-hot select: [2]=div, [1]=mul, [0]=add; combinational
- req_thread  out  2  thread of selected result; 0 when nothing selected
- div_hold  out  1  divide valid but not selected; the pipe holds its result
- mul_hold  out  1  multiply valid but not selected
- add_hold  out  1  add valid but not selected
- fp_cpx_req_cq  out  1  registered; CPX request aligned with the registered result data
- credit_err  out  1  sticky: a credit was returned while the counter was already full

## Operation
- Eligibility: a pipe is eligible when its vld is 1 and `credits != 0`. When credits == 0, `dest_rdy = 0` and every valid pipe's hold is 1.
- Priority order, first eligible pipe wins:
  1. mul, if promoted
  2. add, if promoted
  3. div
  4. mul
  5. add
- Promoted means the pipe's wait counter == STARVE_LIM.
- Wait counters: mul_wait and add_wait, 4 bits each.
  - +1, saturating at STARVE_LIM, when the pipe is valid and not selected.
  - Cleared when the pipe is selected or its vld is 0.
  - Div needs no counter: it is the highest base priority and can only be outranked by a promoted pipe.
- `dest_rdy` is at most one-hot. `req_thread` = thread of the selected pipe, else 0.
- `x_hold = x_vld & ~dest_rdy[x]`.
- Credit counter, width clog2(CREDITS+1):
  - −1 on a grant (`|dest_rdy`).
  - +1 on `cpx_fp_credit_ret`.
  - Grant and return in the same cycle: counter unchanged.
  - Return when counter == CREDITS and no grant that cycle: counter stays at CREDITS and credit_err sets.
  - Counter never underflows, because no grant is possible at 0.
- `fp_cpx_req_cq` <= `|dest_rdy` each cycle.
- Reset values:
  - credits = CREDITS
  - mul_wait = add_wait = 0
  - fp_cpx_req_cq = 0
  - credit_err = 0
  - While reset is high, `dest_rdy` = 0 and all holds follow their vld inputs.
- Reset asserted mid-operation discards outstanding credit accounting. The CPX side must be reset in the same cycle.

## Timing
- Select latency is 0: `dest_rdy` and `req_thread` are valid in the same cycle as the vld inputs, in time to gate the data into the output register.
- `fp_cpx_req_cq` rises 1 cycle after the grant, coincident with the result data on the CPX bus.
- A credit returned in cycle N can be used for a grant in cycle N+1. No combinational path runs from `cpx_fp_credit_ret` to `dest_rdy`.
- Sustained throughput is 1 result/cycle when credits never reach 0.
- Back-to-back grants to the same pipe are allowed.
- A held pipe re-presents the same result in the following cycle. The arbiter keeps no copy of it.

## Structure
- Package `fpu_out_pkg` holds:
  - pipe index constants FPU_OUT_DIV=2, FPU_OUT_MUL=1, FPU_OUT_ADD=0
  - the 3-bit one-hot select typedef
- One sub-module, `fpu_out_credit`: a parameterized up/down credit counter with underflow-free decrement, saturating increment and a sticky overflow flag.
- The priority/starvation logic and the request flop stay in the top module.

## Test plan
- Reset, then all three vld=1 with threads div=1, mul=2, add=3 → cycle 0 `dest_rdy`=3'b100, req_thread=1, mul_hold=add_hold=1; next cycle fp_cpx_req_cq=1.
- CREDITS=2, no returns, add_vld held high for 4 cycles → grants in cycles 0–1, then `dest_rdy`=0 and add_hold=1 from cycle 2; one return in cycle 3 → grant in cycle 4.
- div_vld and add_vld held high with credits plentiful → add held 7 cycles, granted on the 8th (add_wait=7), then div wins again and add_wait clears.
- mul_wait and add_wait both at STARVE_LIM with div valid → `dest_rdy`=3'b010.
- Grant and credit return in the same cycle with credits=1 → counter stays at 1; return with counter=2 and no grant → credit_err=1 and stays 1 until reset.
- Reset asserted with credits=0 and both counters nonzero → next cycle credits=2, counters 0, fp_cpx_req_cq=0, credit_err=0.
